// File: rtl/arm_imm_pkg.sv
// arm_imm_pkg: shared types and constants for the rotated-immediate encoder.
package arm_imm_pkg;
    localparam int ROT_STEPS = 16;
    localparam int IMM_W     = 8;
    localparam int ROT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;
endpackage

// File: rtl/arm_imm_rot_check.sv
// arm_imm_rot_check: tests one rotate candidate by rotating the value left by 2*r.
module arm_imm_rot_check
    import arm_imm_pkg::*;
(
    input  logic [31:0]      value,
    input  logic [ROT_W-1:0] r,
    output logic             hit,
    output logic [IMM_W-1:0] imm8
);
    logic [5:0]  sh;
    logic [31:0] rot;

    // A shift by 32 yields zero, so r=0 collapses to the plain value.
    assign sh   = {1'b0, r, 1'b0};
    assign rot  = (value << sh) | (value >> (6'd32 - sh));
    assign hit  = rot[31:IMM_W] == '0;
    assign imm8 = rot[IMM_W-1:0];
endmodule

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder: finds the canonical {rotate, imm8} operand2 encoding of a 32-bit constant.
module arm_imm_encoder #(
    parameter int CHECKS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic [31:0] req_value,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_found,
    output logic [3:0]  resp_rotate,
    output logic [7:0]  resp_imm8,
    output logic [11:0] resp_field
);
    import arm_imm_pkg::*;

    localparam int C = CHECKS_PER_CYCLE;

    state_t                      state, next_state;
    logic [ROT_W-1:0]            cnt, cnt_d;
    logic [31:0]                 val, val_d;
    logic                        found, found_d;
    logic [ROT_W-1:0]            rot, rot_d;
    logic [IMM_W-1:0]            imm, imm_d;
    logic [C-1:0]                hits;
    logic [C-1:0][IMM_W-1:0]     imms;
    logic [C-1:0][ROT_W-1:0]     cands;
    logic                        any_hit;
    logic [ROT_W-1:0]            hit_rot;
    logic [IMM_W-1:0]            hit_imm;
    logic                        last;

    for (genvar g = 0; g < C; g++) begin : g_chk
        assign cands[g] = cnt + ROT_W'(g);
        arm_imm_rot_check u_chk (
            .value(val),
            .r    (cands[g]),
            .hit  (hits[g]),
            .imm8 (imms[g])
        );
    end

    // Walk from the highest lane down so the lowest hitting candidate wins.
    always_comb begin
        any_hit = 1'b0;
        hit_rot = '0;
        hit_imm = '0;
        for (int i = C - 1; i >= 0; i--) begin
            if (hits[i]) begin
                any_hit = 1'b1;
                hit_rot = cands[i];
                hit_imm = imms[i];
            end
        end
    end

    assign last = ({1'b0, cnt} + 5'(C)) == 5'(ROT_STEPS);

    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        val_d      = val;
        found_d    = found;
        rot_d      = rot;
        imm_d      = imm;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    val_d      = req_value;
                    cnt_d      = '0;
                    next_state = SEARCH;
                end
            end
            SEARCH: begin
                if (any_hit) begin
                    found_d    = 1'b1;
                    rot_d      = hit_rot;
                    imm_d      = hit_imm;
                    next_state = DONE;
                end else if (last) begin
                    found_d    = 1'b0;
                    rot_d      = '0;
                    imm_d      = '0;
                    next_state = DONE;
                end else begin
                    cnt_d = cnt + ROT_W'(C);
                end
            end
            DONE: begin
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            cnt   <= '0;
            val   <= '0;
            found <= 1'b0;
            rot   <= '0;
            imm   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
            val   <= val_d;
            found <= found_d;
            rot   <= rot_d;
            imm   <= imm_d;
        end
    end

    assign req_ready   = state == IDLE;
    assign resp_valid  = state == DONE;
    assign resp_found  = found;
    assign resp_rotate = rot;
    assign resp_imm8   = imm;
    assign resp_field  = {rot, imm};
endmodule

// File: doc/arm_imm_encoder.md
ARM_IMM_ENCODER -- requirements
Module: arm_imm_encoder

Interface
REQ-001 SHALL have parameter CHECKS_PER_CYCLE, default 1, meaning rotation candidates evaluated per search cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request carries a 32-bit constant to encode.
REQ-005 SHALL have port req_value  input  32  constant to encode as a data-processing rotated immediate.
REQ-006 SHALL have port req_ready  output  1  encoder accepts a request this cycle.
REQ-007 SHALL have port resp_valid  output  1  result available.
REQ-008 SHALL have port resp_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port resp_found  output  1  constant is encodable.
REQ-010 SHALL have port resp_rotate  output  4  rotate field, inst[11:8] encoding.
REQ-011 SHALL have port resp_imm8  output  8  immediate field, inst[7:0] encoding.
REQ-012 SHALL have port resp_field  output  12  {resp_rotate, resp_imm8}, ready to drop into inst[11:0].

Function
REQ-013 SHALL implement the inverse of the operand2 immediate decode: value == imm8 rotated right by 2*rotate.
REQ-014 SHALL test candidate r by rotating req_value left by 2*r; hit when bits [31:8] of the result are zero, imm8 = bits [7:0].
REQ-015 SHALL report the lowest hitting r (canonical encoding); value 0 yields rotate 0, imm8 0.
REQ-016 SHALL use FSM states IDLE, SEARCH, DONE.
REQ-017 IDLE: req_ready=1; on req_valid capture req_value, clear rotation counter, go to SEARCH.
REQ-018 SEARCH: evaluate candidates counter .. counter+CHECKS_PER_CYCLE-1; on any hit register lowest hit, found=1, go to DONE.
REQ-019 SEARCH, no hit, last group (counter+CHECKS_PER_CYCLE == 16): register found=0, rotate=0, imm8=0, go to DONE; otherwise counter += CHECKS_PER_CYCLE.
REQ-020 DONE: resp_valid=1, result outputs stable; on resp_ready go to IDLE.
REQ-021 req_ready SHALL be 0 in SEARCH and DONE; no request accepted while busy, even on the cycle resp_ready retires DONE.
REQ-022 resp_valid and resp_* SHALL not change while resp_valid=1 and resp_ready=0.
REQ-023 Latency: request accepted at edge T, hit at candidate r -> resp_valid from T+1+floor(r/CHECKS_PER_CYCLE)+1; not-found -> T+1+16/CHECKS_PER_CYCLE.
REQ-024 Rotation counter SHALL be 4 bits wide; it never wraps past 15 within one search.
REQ-025 req_value SHALL be sampled only at acceptance; later changes are ignored.

Reset
REQ-026 rst_b low SHALL force IDLE asynchronously, at any time including mid-SEARCH or DONE; any in-flight request is discarded.
REQ-027 Reset values: req_ready=1, resp_valid=0, resp_found=0, resp_rotate=0, resp_imm8=0, resp_field=0, counter=0, captured value=0.
REQ-028 First request SHALL be accepted on the first rising edge with rst_b high and req_valid=1.

Structure
REQ-029 FSM state enum, ROT_STEPS=16, IMM_W=8 and ROT_W=4 SHALL live in shared package arm_imm_pkg.
REQ-030 SHALL instantiate CHECKS_PER_CYCLE copies of combinational sub-module arm_imm_rot_check (in: value, r; out: hit, imm8).
REQ-031 Priority selection of the lowest hit SHALL be inside arm_imm_encoder, not in the sub-module.

Verification (CHECKS_PER_CYCLE=1 unless stated)
REQ-032 0x000000FF accepted at T -> resp_valid at T+2, found=1, rotate=0, imm8=0xFF, field=0x0FF.
REQ-033 0xFF000000 -> resp_valid at T+6, found=1, rotate=4, imm8=0xFF, field=0x4FF.
REQ-034 0x000003FC -> resp_valid at T+17, found=1, rotate=15, imm8=0xFF; 0x00000101 -> resp_valid at T+17, found=0, field=0x000.
REQ-035 Backpressure: hold resp_ready=0 for 5 cycles in DONE with req_valid=1 -> outputs stable, req_ready=0, no second capture; resp_ready=1 -> IDLE next edge.
REQ-036 Reset mid-SEARCH (0x101, rst_b low at T+5) -> immediately req_ready=1, resp_valid=0; next request 0x0 -> found=1, field=0x000 at T'+2.
REQ-037 CHECKS_PER_CYCLE=4: 0xFF000000 -> resp_valid at T+3, rotate=4; 0x101 -> resp_valid at T+5, found=0.
